// File: rtl/stream_argmax_if.sv
// Valid/ready stream bundle for stream_argmax: element input side, result output side.
// slave is the argmax block itself; master is the producer/consumer pair driving it.
interface stream_argmax_if #(
  parameter int WIDTH = 3,
  parameter int COUNT = 4
);
  localparam int IDX_W = $clog2(COUNT);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             find_min;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [WIDTH-1:0] out_value;
  logic             out_tie;

  modport slave (
    input  in_valid, in_data, find_min, signed_mode, out_ready,
    output in_ready, out_valid, out_index, out_value, out_tie
  );

  modport master (
    output in_valid, in_data, find_min, signed_mode, out_ready,
    input  in_ready, out_valid, out_index, out_value, out_tie
  );
endinterface

// File: rtl/stream_argmax.sv
// Streaming arg-extreme finder: accumulates COUNT elements per frame and reports the
// index/value of the max or min element (unsigned or signed) plus a tie flag.
module stream_argmax #(
  parameter int WIDTH = 3,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  stream_argmax_if.slave   bus
);
  localparam int IDX_W = $clog2(COUNT);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] best_val;
  logic [IDX_W-1:0] best_idx;
  logic             best_tie;
  logic             mode_min;
  logic             mode_signed;
  logic [WIDTH-1:0] res_val;
  logic [IDX_W-1:0] res_idx;
  logic             res_tie;

  logic             accept;
  logic             last;
  logic             greater;
  logic             equal;
  logic             better;
  logic [WIDTH-1:0] nxt_val;
  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_tie;

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_index = res_idx;
  assign bus.out_value = res_val;
  assign bus.out_tie   = res_tie;

  assign accept  = bus.in_valid && (state == ACCUM) && !flush;
  assign last    = (cnt == IDX_W'(COUNT - 1));
  assign greater = mode_signed ? ($signed(bus.in_data) > $signed(best_val))
                               : (bus.in_data > best_val);
  assign equal   = (bus.in_data == best_val);
  assign better  = mode_min ? (!greater && !equal) : greater;

  // Running best after folding in the current element; lowest index wins on ties.
  always_comb begin
    nxt_val = best_val;
    nxt_idx = best_idx;
    nxt_tie = best_tie;
    if (cnt == '0) begin
      nxt_val = bus.in_data;
      nxt_idx = '0;
      nxt_tie = 1'b0;
    end else if (better) begin
      nxt_val = bus.in_data;
      nxt_idx = cnt;
      nxt_tie = 1'b0;
    end else if (equal) begin
      nxt_tie = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ACCUM;
      cnt         <= '0;
      best_val    <= '0;
      best_idx    <= '0;
      best_tie    <= 1'b0;
      mode_min    <= 1'b0;
      mode_signed <= 1'b0;
      res_val     <= '0;
      res_idx     <= '0;
      res_tie     <= 1'b0;
    end else if (flush) begin
      state <= ACCUM;
      cnt   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            best_val <= nxt_val;
            best_idx <= nxt_idx;
            best_tie <= nxt_tie;
            // Mode is frozen for the frame at element 0.
            if (cnt == '0) begin
              mode_min    <= bus.find_min;
              mode_signed <= bus.signed_mode;
            end
            if (last) begin
              res_val <= nxt_val;
              res_idx <= nxt_idx;
              res_tie <= nxt_tie;
              cnt     <= '0;
              state   <= HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // Element 0 always loads directly, so the latched mode only matters from element 1.
  // The comparators above therefore read the registered mode bits without bypass.
endmodule

// File: tb/tb_stream_argmax.sv
// Randomized self-checking bench for stream_argmax: a 3-bit/4-element instance and an
// 8-bit/5-element instance, checked against a scan-and-count reference model.
module tb_stream_argmax;
  logic clk;
  logic rstn;
  logic flush;
  int   total;
  int   bad;
  int   exp_idx;
  int   exp_val;
  int   exp_tie;

  stream_argmax_if #(.WIDTH(3), .COUNT(4)) a ();
  stream_argmax_if #(.WIDTH(8), .COUNT(5)) b ();

  stream_argmax #(.WIDTH(3), .COUNT(4)) dut_a (.clk(clk), .rstn(rstn), .flush(flush), .bus(a));
  stream_argmax #(.WIDTH(8), .COUNT(5)) dut_b (.clk(clk), .rstn(rstn), .flush(flush), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: map each element to a rank key, find the best key, first position holding
  // it, and how many times it occurs.
  function automatic void refModel(input int v[8], input int n, input int w, input bit fm,
                                   input bit sm, output int idx, output int val, output int tie);
    int key[8];
    int best;
    int hits;
    for (int i = 0; i < n; i++) begin
      key[i] = (sm && v[i] >= (1 << (w - 1))) ? v[i] - (1 << w) : v[i];
      if (fm) key[i] = -key[i];
    end
    best = key[0];
    for (int i = 1; i < n; i++) if (key[i] > best) best = key[i];
    idx  = -1;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      if (key[i] == best) begin
        hits++;
        if (idx < 0) idx = i;
      end
    end
    val = v[idx];
    tie = (hits > 1) ? 1 : 0;
  endfunction

  task automatic driveA(input int d, input bit fm, input bit sm, input int gap);
    int w;
    repeat (gap) begin
      a.in_valid = 1'b0;
      a.in_data  = 3'($urandom);
      @(posedge clk); #1;
    end
    a.in_valid    = 1'b1;
    a.in_data     = 3'(d);
    a.find_min    = fm;
    a.signed_mode = sm;
    w = 0;
    while (!a.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!a.in_ready) checkOutput("a_accept_timeout", 0, 1);
    @(posedge clk); #1;
    a.in_valid = 1'b0;
    a.in_data  = 3'($urandom);
  endtask

  task automatic driveB(input int d, input bit fm, input bit sm);
    int w;
    b.in_valid    = 1'b1;
    b.in_data     = 8'(d);
    b.find_min    = fm;
    b.signed_mode = sm;
    w = 0;
    while (!b.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!b.in_ready) checkOutput("b_accept_timeout", 0, 1);
    @(posedge clk); #1;
    b.in_valid = 1'b0;
    b.in_data  = 8'($urandom);
  endtask

  // Sends one frame to the 3-bit instance; later elements carry random mode bits which
  // must be ignored. Optionally stalls out_ready and finally completes the handshake.
  task automatic applyStimulus(input int v[4], input bit fm, input bit sm, input int maxgap,
                               input int hold, input bit rel);
    int e[8];
    for (int k = 0; k < 4; k++) begin
      driveA(v[k], (k == 0) ? fm : 1'($urandom), (k == 0) ? sm : 1'($urandom),
             (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      e[k] = v[k];
    end
    for (int k = 4; k < 8; k++) e[k] = 0;
    refModel(e, 4, 3, fm, sm, exp_idx, exp_val, exp_tie);
    checkOutput("a_valid_latency", 32'(a.out_valid), 1);
    checkOutput("a_index", 32'(a.out_index), 32'(exp_idx));
    checkOutput("a_value", 32'(a.out_value), 32'(exp_val));
    checkOutput("a_tie", 32'(a.out_tie), 32'(exp_tie));
    checkOutput("a_ready_in_hold", 32'(a.in_ready), 0);
    repeat (hold) begin
      a.in_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput("a_hold_valid", 32'(a.out_valid), 1);
      checkOutput("a_hold_ready", 32'(a.in_ready), 0);
      checkOutput("a_hold_value", 32'(a.out_value), 32'(exp_val));
      checkOutput("a_hold_index", 32'(a.out_index), 32'(exp_idx));
    end
    a.in_valid = 1'b0;
    if (rel) begin
      a.out_ready = 1'b1;
      @(posedge clk); #1;
      a.out_ready = 1'b0;
      checkOutput("a_release_valid", 32'(a.out_valid), 0);
      checkOutput("a_release_ready", 32'(a.in_ready), 1);
      checkOutput("a_kept_value", 32'(a.out_value), 32'(exp_val));
    end
  endtask

  task automatic applyFrameB(input int v[5], input bit fm, input bit sm);
    int e[8];
    for (int k = 0; k < 5; k++) begin
      driveB(v[k], (k == 0) ? fm : 1'($urandom), (k == 0) ? sm : 1'($urandom));
      e[k] = v[k];
    end
    for (int k = 5; k < 8; k++) e[k] = 0;
    refModel(e, 5, 8, fm, sm, exp_idx, exp_val, exp_tie);
    checkOutput("b_valid_latency", 32'(b.out_valid), 1);
    checkOutput("b_index", 32'(b.out_index), 32'(exp_idx));
    checkOutput("b_value", 32'(b.out_value), 32'(exp_val));
    checkOutput("b_tie", 32'(b.out_tie), 32'(exp_tie));
    b.out_ready = 1'b1;
    @(posedge clk); #1;
    b.out_ready = 1'b0;
    checkOutput("b_release_ready", 32'(b.in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int v[4];
    int w5[5];
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    flush = 1'b0;
    a.in_valid = 1'b0; a.in_data = '0; a.find_min = 1'b0; a.signed_mode = 1'b0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.find_min = 1'b0; b.signed_mode = 1'b0; b.out_ready = 1'b0;
    #23;
    checkOutput("rst_in_ready", 32'(a.in_ready), 1);
    checkOutput("rst_out_valid", 32'(a.out_valid), 0);
    checkOutput("rst_index", 32'(a.out_index), 0);
    checkOutput("rst_value", 32'(a.out_value), 0);
    checkOutput("rst_tie", 32'(a.out_tie), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed frames");
    applyStimulus('{1, 2, 3, 4}, 1'b0, 1'b0, 0, 0, 1'b1);
    applyStimulus('{7, 7, 5, 3}, 1'b0, 1'b0, 0, 0, 1'b1);
    applyStimulus('{2, 7, 7, 3}, 1'b0, 1'b0, 0, 0, 1'b1);
    applyStimulus('{7, 7, 7, 7}, 1'b0, 1'b0, 0, 0, 1'b1);
    applyStimulus('{6, 6, 5, 5}, 1'b1, 1'b0, 0, 0, 1'b1);
    applyStimulus('{3, 7, 4, 0}, 1'b0, 1'b1, 0, 0, 1'b1);
    applyStimulus('{3, 7, 4, 0}, 1'b1, 1'b1, 0, 0, 1'b1);
    applyStimulus('{3, 7, 4, 0}, 1'b0, 1'b0, 0, 0, 1'b1);
    applyStimulus('{2, 7, 7, 3}, 1'b0, 1'b0, 3, 5, 1'b1);

    $display("[TB] flush mid-frame");
    driveA(7, 1'b0, 1'b0, 0);
    driveA(7, 1'b0, 1'b0, 0);
    flush = 1'b1; a.in_valid = 1'b1; a.in_data = 3'd7;
    @(posedge clk); #1;
    flush = 1'b0; a.in_valid = 1'b0;
    applyStimulus('{1, 0, 2, 0}, 1'b0, 1'b0, 0, 0, 1'b1);

    $display("[TB] flush during hold");
    applyStimulus('{5, 1, 6, 2}, 1'b1, 1'b0, 0, 1, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_hold_valid", 32'(a.out_valid), 0);
    checkOutput("flush_hold_ready", 32'(a.in_ready), 1);
    checkOutput("flush_hold_value", 32'(a.out_value), 32'(exp_val));
    checkOutput("flush_hold_index", 32'(a.out_index), 32'(exp_idx));

    $display("[TB] random frames");
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 4; k++) v[k] = int'($urandom_range(0, 7));
      applyStimulus(v, 1'($urandom), 1'($urandom), 2, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("[TB] reset during hold");
    applyStimulus('{4, 6, 1, 6}, 1'b0, 1'b0, 0, 0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(a.out_valid), 0);
    checkOutput("arst_index", 32'(a.out_index), 0);
    checkOutput("arst_value", 32'(a.out_value), 0);
    checkOutput("arst_tie", 32'(a.out_tie), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    checkOutput("arst_ready", 32'(a.in_ready), 1);
    applyStimulus('{0, 3, 3, 1}, 1'b0, 1'b0, 1, 0, 1'b1);

    $display("[TB] COUNT=5 WIDTH=8 instance");
    applyFrameB('{9, 200, 200, 1, 255}, 1'b0, 1'b0);
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < 5; k++) w5[k] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255))
                                                                      : int'($urandom_range(126, 130));
      applyFrameB(w5, 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_argmax.md
Name: stream_argmax

Overview:
- Sequential, parametrised successor to the combinational 4-input max-index finder.
- Accepts a frame of COUNT values of WIDTH bits, one per accepted beat on a valid/ready stream.
- Reports the index and value of the extreme element (max or min, unsigned or signed), plus a tie flag.
- Sits between a data producer and a consumer, both with full back-pressure.

Parameters:
WIDTH, 3, bit width of each element
COUNT, 4, elements per frame (>=2)
IDX_W, $clog2(COUNT), index width (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
flush  input  1  synchronous abort of the current frame/result
in_valid  input  1  producer has an element
in_ready  output  1  block can accept an element
in_data  input  WIDTH  element value
find_min  input  1  0 = find maximum, 1 = find minimum; sampled on element 0
signed_mode  input  1  1 = compare as two's complement; sampled on element 0
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_index  output  IDX_W  position of the extreme element within the frame
out_value  output  WIDTH  extreme value
out_tie  output  1  extreme value occurred more than once in the frame

Behaviour:
- Clock and reset: single clock clk; rstn is asynchronous, active-low. Reset takes effect immediately and applies regardless of state.
- Reset values:
  - state = ACCUM, element counter = 0.
  - in_ready = 1, out_valid = 0.
  - out_index = 0, out_value = 0, out_tie = 0.
  - Latched mode bits = 0.
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
- Input accept: an element is accepted on a rising edge with in_valid && in_ready.
- Element 0 (counter = 0):
  - Load running best = in_data, best index = 0, tie = 0.
  - Latch find_min and signed_mode for the whole frame.
  - Mode changes after element 0 are ignored until the next frame.
- Element k (k >= 1), compared against the running best using the latched mode:
  - Strictly better (greater for max, smaller for min): replace value and index with in_data and k; clear tie.
  - Equal: keep the existing index (lowest index wins); set tie.
  - Worse: no change.
- Counter: increments per accepted element. When element COUNT-1 is accepted, the counter wraps to 0 and state moves to HOLD.
- Latency: out_valid rises on the clock edge that accepts the last element. Results are visible in the cycle after the last element is accepted.
- Results are registered. out_index, out_value and out_tie are stable while out_valid = 1.
- HOLD:
  - Results are held until out_valid && out_ready on a rising edge; the block then returns to ACCUM.
  - in_ready = 1 from the next cycle.
  - There is no same-cycle input acceptance during HOLD (minimum frame period COUNT+1 cycles with out_ready held at 1).
  - out_index/out_value/out_tie keep their last values after the handshake until overwritten by the next frame's completion.
- Signed compare: operands are interpreted as two's complement WIDTH-bit values, with no extension beyond WIDTH.
- flush (sampled on a clock edge, priority over every handshake in the same cycle):
  - Counter = 0, state = ACCUM, out_valid = 0.
  - A partial frame is discarded; a pending result is dropped.
  - Output data registers are unchanged.
- Simultaneous in_valid with flush: the element is not accepted.
- Reset mid-frame or mid-HOLD: all state is lost; the next accepted element is element 0.
- in_data while in_valid = 0 is don't-care and must not affect any state.
- COUNT not a power of two: the counter still wraps at COUNT-1; out_index never exceeds COUNT-1.

Test Plan:
1. Unsigned max, frame {1,2,3,4}, in_valid held high, out_ready = 1 -> out_valid one cycle after the 4th accept, index = 3, value = 4, tie = 0; in_ready high next cycle.
2. Unsigned max, frame {7,7,5,3} -> index = 0, value = 7, tie = 1. Then frame {2,7,7,3} -> index = 1, tie = 1. Then {7,7,7,7} -> index = 0, tie = 1.
3. find_min = 1, frame {6,6,5,5} -> index = 2, value = 5, tie = 1. Toggle find_min to 0 at element 2 -> result unchanged (mode latched).
4. signed_mode = 1, frame {3,7,4,0} (3,-1,-4,0): max -> index = 0, value = 3'b011; min -> index = 2, value = 3'b100, tie = 0. Same frame unsigned max -> index = 1, value = 7.
5. Back-pressure and bubbles:
   - Insert in_valid gaps mid-frame -> identical results.
   - Hold out_ready = 0 for 5 cycles -> out_valid stays high, outputs stable, in_ready = 0 throughout; accepts resume the cycle after out_ready rises.
6. Abort and reset:
   - Assert flush after 2 elements -> counter resets; the next 4 elements form a fresh frame.
   - Deassert rstn mid-HOLD -> out_valid falls immediately (async), outputs = 0, in_ready = 1 after release.
   - With COUNT = 5, WIDTH = 8, frame {9,200,200,1,255} -> index = 4, value = 255, tie = 0.
